// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared types and defaults for the memory port arbiter
package riscv_cpu_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT_RESP
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR,
    OWNER_DATA
  } arb_owner_e;

  localparam int MEM_AW_DEF       = 32;
  localparam int MEM_DW_DEF       = 32;
  localparam int ARB_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/LSU arbiter in front of a single-port memory
module mem_port_arbiter
  import riscv_cpu_pkg::*;
#(
  parameter int MEM_AW   = MEM_AW_DEF,
  parameter int MEM_DW   = MEM_DW_DEF,
  parameter int MAX_WAIT = ARB_MAX_WAIT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_req_i,
  input  logic [MEM_AW-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [MEM_DW-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [MEM_DW/8-1:0] data_be_i,
  input  logic [MEM_AW-1:0]   data_addr_i,
  input  logic [MEM_DW-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [MEM_DW-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [MEM_DW/8-1:0] mem_be_o,
  output logic [MEM_AW-1:0]   mem_addr_o,
  output logic [MEM_DW-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [MEM_DW-1:0]   mem_rdata_i,
  output logic                proto_err_o
);

  localparam int BW = MEM_DW / 8;
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(MAX_WAIT);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic [CW-1:0] starve_q;

  logic starved;
  logic pick_data;
  logic pick_instr;
  logic idle;
  logic grant_data;
  logic grant_instr;

  // Fetch overrides data only once it has lost MAX_WAIT grants in a row.
  // Outputs are forced quiet while reset is held, hence the rst_i term in idle.
  assign starved     = instr_req_i && (starve_q == STARVE_MAX);
  assign pick_data   = data_req_i && !starved;
  assign pick_instr  = instr_req_i && !pick_data;
  assign idle        = (state_q == ARB_IDLE) && !rst_i;
  assign grant_data  = idle && pick_data && mem_gnt_i;
  assign grant_instr = idle && pick_instr && mem_gnt_i;

  // Next-state and output decode: memory request mux in IDLE, response routing in WAIT_RESP
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (idle && pick_data) begin
          mem_req_o   = 1'b1;
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end else if (idle && pick_instr) begin
          mem_req_o   = 1'b1;
          mem_be_o    = {BW{1'b1}};
          mem_addr_o  = instr_addr_i;
        end
        data_gnt_o  = grant_data;
        instr_gnt_o = grant_instr;
        if (grant_data || grant_instr) begin
          state_d = ARB_WAIT_RESP;
          owner_d = grant_data ? OWNER_DATA : OWNER_INSTR;
        end
      end
      ARB_WAIT_RESP: begin
        if (mem_rvalid_i) begin
          if (owner_q == OWNER_DATA) begin
            data_rvalid_o = 1'b1;
            data_rdata_o  = mem_rdata_i;
          end else begin
            instr_rvalid_o = 1'b1;
            instr_rdata_o  = mem_rdata_i;
          end
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, owner and protocol-error registers; a response seen in IDLE is flagged next cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_DATA;
      proto_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      proto_err_o <= (state_q == ARB_IDLE) && mem_rvalid_i;
    end
  end

  // Starvation counter: counts data wins while fetch waits, cleared once fetch wins or stops asking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (!instr_req_i || grant_instr) begin
      starve_q <= '0;
    end else if (grant_data && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

endmodule
